// File: rtl/mem_walker_stride_mc_pkg.sv
// mem_walker_pkg: shared definitions for the multi-channel strided address walker.
//   - DEF_* : default parameter values used by the top, channel and interface
//   - ch_w_f: channel-select width, max(1, clog2(n))
//   - sext_f: sign-extends the low w bits of a value to 64 bits; callers
//             truncate the result to their address width (ADDR_WIDTH <= 64)
package mem_walker_pkg;

  localparam int DEF_ADDR_WIDTH    = 48;
  localparam int DEF_ADDR_STRIDE_W = 16;
  localparam int DEF_LOOP_ID_W     = 5;
  localparam int DEF_NUM_CH        = 2;

  function automatic int ch_w_f(input int n);
    if (n <= 1) return 1;
    return $clog2(n);
  endfunction

  // Flip the sign bit and subtract its weight: a branch-free sign extension
  // for any field width w in 1..64.
  function automatic logic [63:0] sext_f(input logic [63:0] v, input int w);
    logic [63:0] msb;
    logic [63:0] mask;
    msb  = 64'd1 << (w - 1);
    mask = (msb << 1) - 64'd1;
    return ((v & mask) ^ msb) - msb;
  endfunction

endpackage

// File: rtl/mem_walker_stride_mc_if.sv
// mem_walker_stride_mc_if: loop-controller / config / address-output bundle
// for the multi-channel walker.
//   master: loop controller + consumer side (drives base/loop/config/addr_out_ready)
//   slave : walker side (drives loop_index_ready, addr_out, addr_out_valid)
//
// Handshakes (both valid/ready, transfer on the rising edge where both are 1):
//   loop_index_valid/loop_index_ready : step request; ready = !addr_out_valid || addr_out_ready.
//   addr_out_valid/addr_out_ready     : once valid rises, addr_out stays stable and valid
//                                       stays high until the cycle ready is seen high.
// loop_init/enter/exit, loop_ctrl_done and config writes are single-cycle strobes
// that are always accepted.
interface mem_walker_stride_mc_if
  import mem_walker_pkg::*;
#(
  parameter int ADDR_WIDTH    = DEF_ADDR_WIDTH,
  parameter int ADDR_STRIDE_W = DEF_ADDR_STRIDE_W,
  parameter int LOOP_ID_W     = DEF_LOOP_ID_W,
  parameter int NUM_CH        = DEF_NUM_CH
) ();
  localparam int CH_W = ch_w_f(NUM_CH);

  logic [NUM_CH*ADDR_WIDTH-1:0] base_addr;
  logic                         loop_init;
  logic                         loop_enter;
  logic                         loop_exit;
  logic [LOOP_ID_W-1:0]         loop_index;
  logic                         loop_index_valid;
  logic                         loop_index_ready;
  logic                         loop_ctrl_done;
  logic                         cfg_addr_stride_v;
  logic [CH_W-1:0]              cfg_addr_stride_ch;
  logic [ADDR_STRIDE_W-1:0]     cfg_addr_stride;
  logic [NUM_CH*ADDR_WIDTH-1:0] addr_out;
  logic                         addr_out_valid;
  logic                         addr_out_ready;

  modport master (
    output base_addr, loop_init, loop_enter, loop_exit, loop_index,
           loop_index_valid, loop_ctrl_done, cfg_addr_stride_v,
           cfg_addr_stride_ch, cfg_addr_stride, addr_out_ready,
    input  loop_index_ready, addr_out, addr_out_valid
  );

  modport slave (
    input  base_addr, loop_init, loop_enter, loop_exit, loop_index,
           loop_index_valid, loop_ctrl_done, cfg_addr_stride_v,
           cfg_addr_stride_ch, cfg_addr_stride, addr_out_ready,
    output loop_index_ready, addr_out, addr_out_valid
  );
endinterface

// File: rtl/mem_walker_stride_mc_channel.sv
// mem_walker_channel: one address stream of the walker.
//   Holds the stride table (written at an auto-incrementing pointer), the
//   per-loop save table, the current address and the update priority
//   init > exit > step. loop_enter always saves the pre-update address.
// Ports:
//   clk, reset      : clock, synchronous active-high reset (cur_addr, wp only)
//   base_addr       : address loaded by loop_init
//   loop_init/enter/exit, loop_index : loop events and the loop they refer to
//   step            : accepted iteration (already qualified by the handshake)
//   loop_ctrl_done  : returns the stride write pointer to 0
//   cfg_wr, cfg_stride : stride write for this channel
//   cur_addr        : current (pre-step) address
module mem_walker_channel
  import mem_walker_pkg::*;
#(
  parameter int ADDR_WIDTH    = DEF_ADDR_WIDTH,
  parameter int ADDR_STRIDE_W = DEF_ADDR_STRIDE_W,
  parameter int LOOP_ID_W     = DEF_LOOP_ID_W
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [ADDR_WIDTH-1:0]    base_addr,
  input  logic                     loop_init,
  input  logic                     loop_enter,
  input  logic                     loop_exit,
  input  logic [LOOP_ID_W-1:0]     loop_index,
  input  logic                     step,
  input  logic                     loop_ctrl_done,
  input  logic                     cfg_wr,
  input  logic [ADDR_STRIDE_W-1:0] cfg_stride,
  output logic [ADDR_WIDTH-1:0]    cur_addr
);
  localparam int DEPTH = 1 << LOOP_ID_W;

  logic [ADDR_STRIDE_W-1:0] stride_q [DEPTH];
  logic [ADDR_STRIDE_W-1:0] stride_d [DEPTH];
  logic [ADDR_WIDTH-1:0]    save_q   [DEPTH];
  logic [ADDR_WIDTH-1:0]    save_d   [DEPTH];
  logic [ADDR_WIDTH-1:0]    cur_q, cur_d;
  logic [LOOP_ID_W-1:0]     wp_q, wp_d;
  logic [ADDR_WIDTH-1:0]    step_inc;

  // Reads the registered table, so a write this cycle is seen next cycle.
  always_comb begin
    step_inc = ADDR_WIDTH'(sext_f(64'(stride_q[loop_index]), ADDR_STRIDE_W));
  end

  // Stride table and write pointer. The pointer wraps naturally at DEPTH.
  always_comb begin
    stride_d = stride_q;
    wp_d     = wp_q;
    if (cfg_wr) begin
      stride_d[wp_q] = cfg_stride;
      wp_d           = wp_q + 1'b1;
    end
    if (loop_ctrl_done) wp_d = '0;
  end

  // Save table and current address. A losing step's increment is dropped;
  // its pre-step address is still emitted by the top level.
  always_comb begin
    save_d = save_q;
    if (loop_enter) save_d[loop_index] = cur_q;
    cur_d = cur_q;
    if (loop_init)      cur_d = base_addr;
    else if (loop_exit) cur_d = save_q[loop_index];
    else if (step)      cur_d = cur_q + step_inc;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cur_q <= '0;
      wp_q  <= '0;
    end else begin
      cur_q <= cur_d;
      wp_q  <= wp_d;
    end
  end

  // Tables keep their contents across reset.
  always_ff @(posedge clk) begin
    stride_q <= stride_d;
    save_q   <= save_d;
  end

  assign cur_addr = cur_q;

endmodule

// File: rtl/mem_walker_stride_mc.sv
// mem_walker_stride_mc: multi-channel strided address walker.
//   Generates NUM_CH mem_walker_channel instances, demuxes stride writes to
//   them, and owns the shared output register with valid/ready backpressure.
//   An accepted step registers every channel's pre-step address into
//   addr_out one cycle later.
// Ports:
//   clk   : clock
//   reset : synchronous active-high reset
//   bus   : mem_walker_stride_mc_if slave modport (loop events, config,
//           step handshake, address output handshake)
module mem_walker_stride_mc
  import mem_walker_pkg::*;
#(
  parameter int ADDR_WIDTH    = DEF_ADDR_WIDTH,
  parameter int ADDR_STRIDE_W = DEF_ADDR_STRIDE_W,
  parameter int LOOP_ID_W     = DEF_LOOP_ID_W,
  parameter int NUM_CH        = DEF_NUM_CH
) (
  input logic                   clk,
  input logic                   reset,
  mem_walker_stride_mc_if.slave bus
);
  logic                                 step_acc;
  logic                                 ready;
  logic [NUM_CH-1:0]                    cfg_wr;
  logic [NUM_CH-1:0][ADDR_WIDTH-1:0]    cur_addr;
  logic                                 valid_q, valid_d;
  logic [NUM_CH*ADDR_WIDTH-1:0]         addr_out_q, addr_out_d;

  always_comb begin
    ready    = !valid_q || bus.addr_out_ready;
    step_acc = bus.loop_index_valid && ready;
  end

  // Writes aimed at a channel that does not exist match no instance.
  always_comb begin
    cfg_wr = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      cfg_wr[c] = bus.cfg_addr_stride_v && (int'(bus.cfg_addr_stride_ch) == c);
    end
  end

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    mem_walker_channel #(
      .ADDR_WIDTH   (ADDR_WIDTH),
      .ADDR_STRIDE_W(ADDR_STRIDE_W),
      .LOOP_ID_W    (LOOP_ID_W)
    ) u_ch (
      .clk           (clk),
      .reset         (reset),
      .base_addr     (bus.base_addr[c*ADDR_WIDTH +: ADDR_WIDTH]),
      .loop_init     (bus.loop_init),
      .loop_enter    (bus.loop_enter),
      .loop_exit     (bus.loop_exit),
      .loop_index    (bus.loop_index),
      .step          (step_acc),
      .loop_ctrl_done(bus.loop_ctrl_done),
      .cfg_wr        (cfg_wr[c]),
      .cfg_stride    (bus.cfg_addr_stride),
      .cur_addr      (cur_addr[c])
    );
  end

  // Output register: load on accept, hold while stalled, drop once consumed.
  always_comb begin
    valid_d    = valid_q;
    addr_out_d = addr_out_q;
    if (step_acc) begin
      valid_d    = 1'b1;
      addr_out_d = cur_addr;
    end else if (bus.addr_out_ready) begin
      valid_d    = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q    <= 1'b0;
      addr_out_q <= '0;
    end else begin
      valid_q    <= valid_d;
      addr_out_q <= addr_out_d;
    end
  end

  assign bus.loop_index_ready = ready;
  assign bus.addr_out_valid   = valid_q;
  assign bus.addr_out         = addr_out_q;

endmodule

// File: tb/tb_mem_walker_stride_mc.sv
module tb_mem_walker_stride_mc;
  localparam int AW = 48;
  localparam int SW = 16;
  localparam int LW = 5;
  localparam int NC = 2;
  localparam int DEPTH = 1 << LW;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  mem_walker_stride_mc_if #(.ADDR_WIDTH(AW), .ADDR_STRIDE_W(SW), .LOOP_ID_W(LW), .NUM_CH(NC)) bus ();

  mem_walker_stride_mc #(.ADDR_WIDTH(AW), .ADDR_STRIDE_W(SW), .LOOP_ID_W(LW), .NUM_CH(NC)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  // ---------------- reference model ----------------
  logic [SW-1:0] m_stride [NC][DEPTH];
  logic [AW-1:0] m_save   [NC][DEPTH];
  bit            m_saved  [DEPTH];
  int            m_wp     [NC];
  logic [AW-1:0] m_cur    [NC];
  logic [AW-1:0] m_out    [NC];
  logic          m_valid;
  logic          m_ready;
  logic          m_acc;
  logic [2*AW-1:0] exp_q [$];

  int checks = 0;
  int failures = 0;

  function automatic logic [AW-1:0] add_m(input logic [AW-1:0] a, input logic [SW-1:0] s);
    longint d;
    d = longint'($signed(s));
    return AW'(longint'(a) + d);
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Applies one clock edge's worth of behaviour to the model, from the
  // inputs currently on the bus.
  task automatic model_update();
    logic [AW-1:0] nxt;
    int idx;
    int ch;
    if (reset) begin
      for (int c = 0; c < NC; c++) begin
        m_cur[c] = '0; m_wp[c] = 0; m_out[c] = '0;
      end
      m_valid = 1'b0;
      m_acc = 1'b0;
      exp_q.delete();
      return;
    end
    idx = int'(bus.loop_index);
    m_acc = bus.loop_index_valid && m_ready;
    if (m_acc) begin
      for (int c = 0; c < NC; c++) m_out[c] = m_cur[c];
      exp_q.push_back({m_cur[1], m_cur[0]});
      m_valid = 1'b1;
    end else if (bus.addr_out_ready) begin
      m_valid = 1'b0;
    end
    for (int c = 0; c < NC; c++) begin
      nxt = m_cur[c];
      if (m_acc) nxt = add_m(m_cur[c], m_stride[c][idx]);
      if (bus.loop_exit) nxt = m_save[c][idx];
      if (bus.loop_init) nxt = bus.base_addr[c*AW +: AW];
      if (bus.loop_enter) m_save[c][idx] = m_cur[c];
      m_cur[c] = nxt;
    end
    if (bus.loop_enter) m_saved[idx] = 1'b1;
    if (bus.cfg_addr_stride_v) begin
      ch = int'(bus.cfg_addr_stride_ch);
      if (ch < NC) begin
        m_stride[ch][m_wp[ch]] = bus.cfg_addr_stride;
        m_wp[ch] = (m_wp[ch] + 1) % DEPTH;
      end
    end
    if (bus.loop_ctrl_done) for (int c = 0; c < NC; c++) m_wp[c] = 0;
  endtask

  // ---------------- driver tasks ----------------
  task automatic clear_pulses();
    bus.loop_init = 1'b0;
    bus.loop_enter = 1'b0;
    bus.loop_exit = 1'b0;
    bus.loop_index_valid = 1'b0;
    bus.loop_ctrl_done = 1'b0;
    bus.cfg_addr_stride_v = 1'b0;
  endtask

  // One cycle: check the combinational ready, clock, then score the outputs.
  task automatic tick();
    logic [2*AW-1:0] e;
    #1;
    m_ready = !m_valid || bus.addr_out_ready;
    check("loop_index_ready", 64'(bus.loop_index_ready), 64'(m_ready));
    model_update();
    @(posedge clk);
    #1;
    check("addr_out_valid", 64'(bus.addr_out_valid), 64'(m_valid));
    if (m_acc) begin
      e = exp_q.pop_front();
      check("emit_ch0", 64'(bus.addr_out[AW-1:0]), 64'(e[AW-1:0]));
      check("emit_ch1", 64'(bus.addr_out[2*AW-1:AW]), 64'(e[2*AW-1:AW]));
    end else if (m_valid) begin
      check("hold_ch0", 64'(bus.addr_out[AW-1:0]), 64'(m_out[0]));
      check("hold_ch1", 64'(bus.addr_out[2*AW-1:AW]), 64'(m_out[1]));
    end
    clear_pulses();
  endtask

  task automatic cfg_write(input int ch, input logic [SW-1:0] val);
    bus.cfg_addr_stride_v = 1'b1;
    bus.cfg_addr_stride_ch = 1'(ch);
    bus.cfg_addr_stride = val;
    tick();
  endtask

  task automatic do_init(input logic [AW-1:0] b0, input logic [AW-1:0] b1);
    bus.base_addr = {b1, b0};
    bus.loop_init = 1'b1;
    tick();
  endtask

  task automatic do_enter(input int idx);
    bus.loop_index = LW'(idx);
    bus.loop_enter = 1'b1;
    tick();
  endtask

  task automatic do_exit(input int idx);
    bus.loop_index = LW'(idx);
    bus.loop_exit = 1'b1;
    tick();
  endtask

  task automatic do_step(input int idx);
    bus.loop_index = LW'(idx);
    bus.loop_index_valid = 1'b1;
    tick();
  endtask

  task automatic expect_out(input string tag, input logic [AW-1:0] e0, input logic [AW-1:0] e1);
    check({tag, "_ch0"}, 64'(bus.addr_out[AW-1:0]), 64'(e0));
    check({tag, "_ch1"}, 64'(bus.addr_out[2*AW-1:AW]), 64'(e1));
  endtask

  // ---------------- directed + random sequence ----------------
  initial begin
    bus.base_addr = '0;
    bus.loop_index = '0;
    bus.cfg_addr_stride_ch = '0;
    bus.cfg_addr_stride = '0;
    bus.addr_out_ready = 1'b1;
    clear_pulses();
    m_valid = 1'b0;
    for (int c = 0; c < NC; c++) begin
      m_cur[c] = '0; m_out[c] = '0; m_wp[c] = 0;
    end
    for (int i = 0; i < DEPTH; i++) m_saved[i] = 1'b0;

    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    check("reset_addr_out", 64'(bus.addr_out[AW-1:0]) | 64'(bus.addr_out[2*AW-1:AW]), 64'd0);
    check("reset_valid", 64'(bus.addr_out_valid), 64'd0);
    check("reset_ready", 64'(bus.loop_index_ready), 64'd1);

    // Fill every stride entry so the model never meets an unwritten one;
    // 32 writes per channel also wraps the pointer back to 0.
    for (int c = 0; c < NC; c++)
      for (int i = 0; i < DEPTH; i++) cfg_write(c, SW'($urandom));
    bus.loop_ctrl_done = 1'b1;
    tick();

    // Basic walk
    cfg_write(0, 16'h0001);
    cfg_write(0, 16'h0004);
    cfg_write(1, 16'hFFFF);
    cfg_write(1, 16'h0008);
    do_init(48'h100, 48'h200);
    do_enter(1);
    do_enter(0);
    do_step(0); expect_out("walk0", 48'h100, 48'h200);
    do_step(0); expect_out("walk1", 48'h101, 48'h1FF);
    do_step(0); expect_out("walk2", 48'h102, 48'h1FE);

    // Exit and outer step
    do_exit(0);
    do_step(1); expect_out("outer", 48'h100, 48'h200);
    do_enter(0);
    do_step(0); expect_out("inner", 48'h104, 48'h208);

    // Backpressure
    do_init(48'h100, 48'h200);
    do_step(0); expect_out("bp_first", 48'h100, 48'h200);
    bus.addr_out_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      do_step(0);
      check("bp_ready_low", 64'(bus.loop_index_ready), 64'd0);
      expect_out("bp_hold", 48'h100, 48'h200);
    end
    bus.addr_out_ready = 1'b1;
    do_step(0); expect_out("bp_resume", 48'h101, 48'h1FF);
    do_step(0); expect_out("bp_next", 48'h102, 48'h1FE);

    // Wrap: both channels' pointers sit at index 2
    cfg_write(0, 16'h0001);
    cfg_write(1, 16'h0001);
    do_init(48'hFFFF_FFFF_FFFF, 48'h10);
    do_step(2); expect_out("wrap0", 48'hFFFF_FFFF_FFFF, 48'h10);
    do_step(2); expect_out("wrap1", 48'h0, 48'h11);

    // Simultaneous init + exit: init wins
    bus.base_addr = {48'h300, 48'h300};
    bus.loop_index = LW'(0);
    bus.loop_init = 1'b1;
    bus.loop_exit = 1'b1;
    tick();
    do_step(0); expect_out("init_vs_exit", 48'h300, 48'h300);

    // Randomised walk against the model
    for (int n = 0; n < 400; n++) begin
      int idx;
      idx = int'($urandom_range(0, 3));
      bus.loop_index = LW'(idx);
      bus.addr_out_ready = ($urandom_range(0, 3) != 0);
      bus.loop_index_valid = $urandom_range(0, 1) == 1;
      if ($urandom_range(0, 15) == 0) begin
        bus.base_addr = {AW'({$urandom, $urandom}), AW'({$urandom, $urandom})};
        bus.loop_init = 1'b1;
      end
      if ($urandom_range(0, 7) == 0) bus.loop_enter = 1'b1;
      if ($urandom_range(0, 7) == 0 && m_saved[idx]) bus.loop_exit = 1'b1;
      if ($urandom_range(0, 3) == 0) begin
        bus.cfg_addr_stride_v = 1'b1;
        bus.cfg_addr_stride_ch = 1'($urandom_range(0, 1));
        bus.cfg_addr_stride = SW'($urandom);
      end
      if ($urandom_range(0, 31) == 0) bus.loop_ctrl_done = 1'b1;
      tick();
    end

    // Reset mid-walk
    bus.addr_out_ready = 1'b1;
    do_step(1);
    do_step(1);
    reset = 1'b1;
    bus.loop_index_valid = 1'b1;
    tick();
    reset = 1'b0;
    check("midrst_addr_out", 64'(bus.addr_out[AW-1:0]) | 64'(bus.addr_out[2*AW-1:AW]), 64'd0);
    check("midrst_valid", 64'(bus.addr_out_valid), 64'd0);
    check("midrst_ready", 64'(bus.loop_index_ready), 64'd1);

    // Pointer back at 0 after reset
    cfg_write(0, 16'h0007);
    cfg_write(1, 16'h0003);
    do_init(48'h1000, 48'h2000);
    do_step(0); expect_out("wp_rst0", 48'h1000, 48'h2000);
    do_step(0); expect_out("wp_rst1", 48'h1007, 48'h2003);

    // Pointer back at 0 after loop_ctrl_done
    cfg_write(0, 16'h0005);
    bus.loop_ctrl_done = 1'b1;
    tick();
    cfg_write(0, 16'hFFFE);
    cfg_write(1, 16'h0010);
    do_init(48'h1000, 48'h2000);
    do_step(0); expect_out("wp_done0", 48'h1000, 48'h2000);
    do_step(0); expect_out("wp_done1", 48'h0FFE, 48'h2010);

    // ---------------- report ----------------
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mem_walker_stride_mc.md
# mem_walker_stride_mc

Multi-channel strided address walker. It sits between the loop controller and the memory-request stage. It tracks NUM_CH independent address streams, one per operand buffer, through nested loops, and adds the signed per-loop stride of each channel on every loop iteration. Compared with the single-channel walker, it adds channel count, signed strides, per-loop save/restore and ready/valid backpressure on the address output.

## Interface
- ADDR_WIDTH, 48, address width per channel
- ADDR_STRIDE_W, 16, stride width per channel; two's-complement
- LOOP_ID_W, 5, loop index width; table depth is 2^LOOP_ID_W
- NUM_CH, 2, number of address channels (≥1)
- CH_W, derived, max(1, clog2(NUM_CH))

Ports:
- clk  in  1  clock; all logic is on the rising edge
- reset  in  1  synchronous, active-high
- base_addr  in  NUM_CH*ADDR_WIDTH  per-channel base address; channel c occupies bits [c*ADDR_WIDTH +: ADDR_WIDTH]
- loop_init  in  1  loads cur_addr from base_addr on all channels
- loop_enter  in  1  saves cur_addr into save table [loop_index]
- loop_exit  in  1  restores cur_addr from save table [loop_index]
- loop_index  in  LOOP_ID_W  loop being entered, exited or stepped
- loop_index_valid  in  1  iteration request: emit the address, then step
- loop_index_ready  out  1  = !addr_out_valid || addr_out_ready
- loop_ctrl_done  in  1  end of layer; clears the stride write pointers
- cfg_addr_stride_v  in  1  stride write strobe
- cfg_addr_stride_ch  in  CH_W  target channel of the write
- cfg_addr_stride  in  ADDR_STRIDE_W  stride value
- addr_out  out  NUM_CH*ADDR_WIDTH  emitted addresses, same packing as base_addr
- addr_out_valid  out  1  addresses valid
- addr_out_ready  in  1  downstream accepts the addresses

## Operation
- **Stride config:** each channel has a stride table and a write pointer wp[c].
  - A write with cfg_addr_stride_v=1 stores cfg_addr_stride at stride[ch][wp[ch]], then wp[ch]++.
  - wp wraps modulo 2^LOOP_ID_W.
  - A write with cfg_addr_stride_ch ≥ NUM_CH is dropped.
  - reset and loop_ctrl_done set every wp to 0. Table contents are not cleared.
- **loop_init:** cur_addr[c] ← base_addr[c] for all c.
- **loop_enter:** save[c][loop_index] ← cur_addr[c], using the value before any same-cycle update.
- **loop_exit:** cur_addr[c] ← save[c][loop_index].
- **Step.** A step is accepted when loop_index_valid && loop_index_ready. On an accepted step:
  - addr_out[c] ← cur_addr[c], which is the pre-step address.
  - addr_out_valid ← 1.
  - cur_addr[c] ← cur_addr[c] + sext(stride[c][loop_index]).
- **Arithmetic:** the stride is sign-extended to ADDR_WIDTH. The sum wraps modulo 2^ADDR_WIDTH and has no saturation.
- **Priority in one cycle (applies to the cur_addr update):**
  - Order is loop_init > loop_exit > step.
  - A step that loses still emits its pre-step address, but its increment is discarded.
  - loop_enter is independent of the others and always saves the pre-update value.
- **Output register:**
  - addr_out_valid clears when addr_out_ready=1 and no new step is accepted.
  - While valid && !ready, addr_out holds and loop_index_ready=0, so no step is lost or duplicated.
- loop_init, loop_enter, loop_exit and config writes are always accepted, regardless of backpressure.

## Timing
- Reset values:
  - addr_out = 0, addr_out_valid = 0, loop_index_ready = 1.
  - cur_addr = 0, wp = 0.
  - Save and stride tables are unaffected by reset.
- Step latency: the address appears on addr_out 1 cycle after acceptance.
  - Full throughput is 1 step per cycle while addr_out_ready=1.
- A stride write in cycle N is visible to a step in cycle N+1 or later.
  - Same-cycle write and read of the same entry returns the old value.
- loop_enter in cycle N followed by loop_exit of the same index in cycle N+1 restores the saved value.
- Reset asserted mid-walk takes effect at the next edge and any pending output is discarded.

## Structure
- Shared package mem_walker_pkg holds:
  - the clog2-based CH_W helper;
  - a sign-extend function (stride → address width);
  - default parameter constants.
- Sub-module mem_walker_channel: one instance per channel, generated NUM_CH times. Each instance holds:
  - its stride table, save table, wp and cur_addr;
  - the adder and priority logic.
- The top level holds the shared output-valid register and ready logic, plus config-write demux.

## Test plan
Default configuration: NUM_CH=2, LOOP_ID_W=5.
- **Basic walk.** Write strides: ch0 = 1, 4; ch1 = 0xFFFF, 8. Set base ch0=0x100, ch1=0x200, then loop_init. Enter idx1, enter idx0, step idx0 three times.
  - Required: ch0 emits 0x100, 0x101, 0x102.
  - Required: ch1 emits 0x200, 0x1FF, 0x1FE.
- **Exit and outer step.** Continuing from the basic walk: exit idx0, step idx1, enter idx0, step idx0.
  - Required: ch0 emits 0x100 then 0x104.
  - Required: ch1 emits 0x200 then 0x208.
- **Backpressure.** Step every cycle while addr_out_ready=0 for 3 cycles.
  - Required: loop_index_ready=0 for those 3 cycles and addr_out held at 0x100.
  - Required: after ready returns, the sequence continues at 0x101 with no gap or repeat.
- **Wrap.** Set ch0 base = 0xFFFF_FFFF_FFFF with stride 1, then step twice.
  - Required: emits 0xFFFF_FFFF_FFFF, then 0x0.
- **Simultaneous events.** Assert loop_init and loop_exit together with base 0x300.
  - Required: cur_addr = 0x300, and the next step emits 0x300.
- **Reset mid-walk and config pointer.** Assert reset during stepping.
  - Required: addr_out=0, addr_out_valid=0, loop_index_ready=1.
  - Required: the next config write on ch0 lands at index 0.
  - Required: loop_ctrl_done also returns wp to 0.
